tile_fetch_sequencer: RTL and testbench

//  Read-side sequencer between the tile BRAM (L1) and the compute engine. Accepts a fetch

---
 rtl/tile_pkg.sv | 26 ++
 rtl/tile_beat_fifo.sv | 40 ++++
 rtl/tile_fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tile_fetch_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types for the tile BRAM read path:
// geometry constants, the output beat and the sequencer state.
package tile_pkg;

  localparam int MAN_WIDTH  = 256;
  localparam int EXP_WIDTH  = 8;
  localparam int BRAM_DEPTH = 512;
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef struct packed {
    logic [MAN_WIDTH-1:0]  man_left;
    logic [MAN_WIDTH-1:0]  man_right;
    logic [EXP_WIDTH-1:0]  exp_left;
    logic [EXP_WIDTH-1:0]  exp_right;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  last;
  } tile_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/tile_beat_fifo.sv
// Two-entry beat FIFO between BRAM capture and the output stream.
// Storage is reset so the stream fields read 0 while empty after reset.
module tile_beat_fifo
  import tile_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       push,
  input  tile_beat_t push_beat,
  input  logic       pop,
  output tile_beat_t head,
  output logic [1:0] count
);

  tile_beat_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/tile_fetch_sequencer.sv
// Tile BRAM read sequencer: issues lockstep reads on four ports,
// captures the registered read data and streams it as beats.
module tile_fetch_sequencer
  import tile_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_left_base,
  input  logic [ADDR_WIDTH-1:0] i_cmd_right_base,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  output logic [ADDR_WIDTH-1:0] o_man_left_rd_addr,
  output logic                  o_man_left_rd_en,
  input  logic [MAN_WIDTH-1:0]  i_man_left_rd_data,
  output logic [ADDR_WIDTH-1:0] o_man_right_rd_addr,
  output logic                  o_man_right_rd_en,
  input  logic [MAN_WIDTH-1:0]  i_man_right_rd_data,
  output logic [ADDR_WIDTH-1:0] o_exp_left_rd_addr,
  output logic                  o_exp_left_rd_en,
  input  logic [EXP_WIDTH-1:0]  i_exp_left_rd_data,
  output logic [ADDR_WIDTH-1:0] o_exp_right_rd_addr,
  output logic                  o_exp_right_rd_en,
  input  logic [EXP_WIDTH-1:0]  i_exp_right_rd_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [MAN_WIDTH-1:0]  o_out_man_left,
  output logic [MAN_WIDTH-1:0]  o_out_man_right,
  output logic [EXP_WIDTH-1:0]  o_out_exp_left,
  output logic [EXP_WIDTH-1:0]  o_out_exp_right,
  output logic [ADDR_WIDTH-1:0] o_out_idx,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done
);

  fetch_state_t          state;
  fetch_state_t          state_nx;
  logic [ADDR_WIDTH-1:0] left_base;
  logic [ADDR_WIDTH-1:0] right_base;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_idx;
  logic                  cmd_ready_q;
  logic                  zero_done_q;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  drained;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] left_addr;
  logic [ADDR_WIDTH-1:0] right_addr;
  tile_beat_t            push_beat;
  tile_beat_t            head;

  assign accept  = i_cmd_valid && cmd_ready_q;
  assign pop     = (count != 2'd0) && i_out_ready;
  assign occ     = {1'b0, count} + {2'b0, inflight};

  // Credit: FIFO entries plus the read in flight never exceed 2
  assign issue   = (state == FETCH)
                && (issued != len_q)
                && (occ < (3'd2 + {2'b0, pop}));
  assign drained = (state == DRAIN)
                && !inflight
                && (count == 2'd0);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (accept && (i_cmd_len != '0)) begin
          state_nx = FETCH;
        end
      end
      (state == FETCH): begin
        if (issue && (issued + LEN_WIDTH'(1) == len_q)) begin
          state_nx = DRAIN;
        end
      end
      (state == DRAIN): begin
        if (drained) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      left_base    <= '0;
      right_base   <= '0;
      len_q        <= '0;
      issued       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      cmd_ready_q  <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      cmd_ready_q <= (state_nx == IDLE);
      zero_done_q <= accept && (i_cmd_len == '0);
      inflight    <= issue;
      if (accept) begin
        left_base  <= i_cmd_left_base;
        right_base <= i_cmd_right_base;
        len_q      <= i_cmd_len;
        issued     <= '0;
      end else if (issue) begin
        issued <= issued + LEN_WIDTH'(1);
      end
      if (issue) begin
        inflight_idx <= issued[ADDR_WIDTH-1:0];
      end
    end
  end

  // Natural width overflow gives the 511 -> 0 wrap
  assign left_addr  = left_base + issued[ADDR_WIDTH-1:0];
  assign right_addr = right_base + issued[ADDR_WIDTH-1:0];

  assign o_man_left_rd_addr  = left_addr;
  assign o_exp_left_rd_addr  = left_addr;
  assign o_man_right_rd_addr = right_addr;
  assign o_exp_right_rd_addr = right_addr;
  assign o_man_left_rd_en    = issue;
  assign o_man_right_rd_en   = issue;
  assign o_exp_left_rd_en    = issue;
  assign o_exp_right_rd_en   = issue;

  always_comb begin
    push_beat           = '0;
    push_beat.man_left  = i_man_left_rd_data;
    push_beat.man_right = i_man_right_rd_data;
    push_beat.exp_left  = i_exp_left_rd_data;
    push_beat.exp_right = i_exp_right_rd_data;
    push_beat.idx       = inflight_idx;
    push_beat.last      = ({1'b0, inflight_idx}
                        == (len_q - LEN_WIDTH'(1)));
  end

  tile_beat_fifo u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign o_out_valid     = (count != 2'd0);
  assign o_out_man_left  = head.man_left;
  assign o_out_man_right = head.man_right;
  assign o_out_exp_left  = head.exp_left;
  assign o_out_exp_right = head.exp_right;
  assign o_out_idx       = head.idx;
  assign o_out_last      = head.last;
  assign o_cmd_ready     = cmd_ready_q;
  assign o_busy          = (state != IDLE);
  assign o_done          = zero_done_q | drained;

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// Bench for tile_fetch_sequencer: BRAM model, queue-based
// expected-stream model and directed command scenarios.
module tb_tile_fetch_sequencer;
  import tile_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_l;
  logic [ADDR_WIDTH-1:0] cmd_r;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [ADDR_WIDTH-1:0] ml_a, mr_a, el_a, er_a;
  logic                  ml_en, mr_en, el_en, er_en;
  logic [MAN_WIDTH-1:0]  ml_d, mr_d;
  logic [EXP_WIDTH-1:0]  el_d, er_d;
  logic                  out_valid;
  logic                  out_ready;
  logic [MAN_WIDTH-1:0]  o_ml, o_mr;
  logic [EXP_WIDTH-1:0]  o_el, o_er;
  logic [ADDR_WIDTH-1:0] o_idx;
  logic                  o_last;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  tile_fetch_sequencer dut (
    .i_clk               (clk),
    .i_reset_n           (rst_n),
    .i_cmd_valid         (cmd_valid),
    .o_cmd_ready         (cmd_ready),
    .i_cmd_left_base     (cmd_l),
    .i_cmd_right_base    (cmd_r),
    .i_cmd_len           (cmd_len),
    .o_man_left_rd_addr  (ml_a),
    .o_man_left_rd_en    (ml_en),
    .i_man_left_rd_data  (ml_d),
    .o_man_right_rd_addr (mr_a),
    .o_man_right_rd_en   (mr_en),
    .i_man_right_rd_data (mr_d),
    .o_exp_left_rd_addr  (el_a),
    .o_exp_left_rd_en    (el_en),
    .i_exp_left_rd_data  (el_d),
    .o_exp_right_rd_addr (er_a),
    .o_exp_right_rd_en   (er_en),
    .i_exp_right_rd_data (er_d),
    .o_out_valid         (out_valid),
    .i_out_ready         (out_ready),
    .o_out_man_left      (o_ml),
    .o_out_man_right     (o_mr),
    .o_out_exp_left      (o_el),
    .o_out_exp_right     (o_er),
    .o_out_idx           (o_idx),
    .o_out_last          (o_last),
    .o_busy              (busy),
    .o_done              (done)
  );

  function automatic logic [MAN_WIDTH-1:0] man_pat(
    input int side, input int a);
    logic [31:0] w;
    w = (32'(side) << 16) | 32'(a) | 32'h5A00_0000;
    return {8{w}};
  endfunction

  function automatic logic [EXP_WIDTH-1:0] exp_pat(
    input int side, input int a);
    return 8'((a * 5 + side * 77) & 255);
  endfunction

  // Registered-read BRAMs preloaded with address patterns
  always @(posedge clk) begin
    if (ml_en) ml_d <= man_pat(0, int'(ml_a));
    if (mr_en) mr_d <= man_pat(1, int'(mr_a));
    if (el_en) el_d <= exp_pat(2, int'(el_a));
    if (er_en) er_d <= exp_pat(3, int'(er_a));
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm,
                     input logic [MAN_WIDTH-1:0] act,
                     input logic [MAN_WIDTH-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [MAN_WIDTH-1:0] ml;
    logic [MAN_WIDTH-1:0] mr;
    logic [EXP_WIDTH-1:0] el;
    logic [EXP_WIDTH-1:0] er;
    int                   idx;
    bit                   last;
  } mbeat_t;

  mbeat_t exp_q[$];
  int     exp_la[$], exp_ra[$];
  int     la_log[$], ra_log[$], rd_cyc[$];
  int     idx_log[$], last_log[$], pop_cyc[$];
  int     acc_cyc[$], done_cyc[$];
  int     cyc = 0;
  int     outstanding = 0;
  bit     done_due = 0;
  bit     hold = 0;
  logic [MAN_WIDTH-1:0]  h_ml, h_mr;
  logic [EXP_WIDTH-1:0]  h_el, h_er;
  logic [ADDR_WIDTH-1:0] h_idx;
  logic                  h_last;

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    la_log.delete();  ra_log.delete();  rd_cyc.delete();
    idx_log.delete(); last_log.delete(); pop_cyc.delete();
    acc_cyc.delete(); done_cyc.delete();
  endtask

  // Compare process: model derived from accepted commands
  int     la, ra, n;
  bit     due_nx;
  mbeat_t e, t;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete(); exp_la.delete(); exp_ra.delete();
      outstanding = 0;
      done_due    = 0;
      hold        = 0;
    end else begin
      due_nx = 0;
      chk("done", done, done_due);
      if (busy) chk("credit", outstanding <= 2, 1);
      if (hold) begin
        chk("stable_valid", out_valid, 1);
        chk("stable_ml", o_ml, h_ml);
        chk("stable_mr", o_mr, h_mr);
        chk("stable_exp", {o_el, o_er}, {h_el, h_er});
        chk("stable_idx", {o_idx, o_last}, {h_idx, h_last});
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc.push_back(cyc);
        n = int'(cmd_len);
        for (int k = 0; k < n; k++) begin
          la = (int'(cmd_l) + k) % BRAM_DEPTH;
          ra = (int'(cmd_r) + k) % BRAM_DEPTH;
          exp_la.push_back(la);
          exp_ra.push_back(ra);
          t.ml   = man_pat(0, la);
          t.mr   = man_pat(1, ra);
          t.el   = exp_pat(2, la);
          t.er   = exp_pat(3, ra);
          t.idx  = k;
          t.last = (k == n - 1);
          exp_q.push_back(t);
        end
        if (n == 0) due_nx = 1;
      end
      if (ml_en || mr_en || el_en || er_en) begin
        chk("en_lockstep", {ml_en, mr_en, el_en, er_en}, 4'hf);
        if (exp_la.size() == 0) begin
          chk("spurious_rd", 1, 0);
        end else begin
          la = exp_la.pop_front();
          ra = exp_ra.pop_front();
          chk("man_l_addr", ml_a, la);
          chk("exp_l_addr", el_a, la);
          chk("man_r_addr", mr_a, ra);
          chk("exp_r_addr", er_a, ra);
        end
        la_log.push_back(int'(ml_a));
        ra_log.push_back(int'(mr_a));
        rd_cyc.push_back(cyc);
        outstanding++;
      end
      hold = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("beat_ml", o_ml, e.ml);
          chk("beat_mr", o_mr, e.mr);
          chk("beat_el", o_el, e.el);
          chk("beat_er", o_er, e.er);
          chk("beat_idx", o_idx, e.idx);
          chk("beat_last", o_last, e.last);
          idx_log.push_back(int'(o_idx));
          last_log.push_back(int'(o_last));
          pop_cyc.push_back(cyc);
          outstanding--;
          if (e.last) due_nx = 1;
        end else begin
          hold   = 1;
          h_ml   = o_ml;   h_mr  = o_mr;
          h_el   = o_el;   h_er  = o_er;
          h_idx  = o_idx;  h_last = o_last;
        end
      end
      if (done) done_cyc.push_back(cyc);
      done_due = due_nx;
    end
  end

  // Consumer: 0 = stalled, 1 = always ready, 2 = toggling
  int rmode = 1;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  task automatic send(input int l, input int r, input int len);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_l     = ADDR_WIDTH'(l);
    cmd_r     = ADDR_WIDTH'(r);
    cmd_len   = LEN_WIDTH'(len);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    chk("cmd_accept_timeout", ok, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctrl"},
        {cmd_ready, ml_en, mr_en, el_en, er_en, ml_a, mr_a,
         el_a, er_a, out_valid, o_el, o_er, o_idx, o_last,
         busy, done}, '0);
    chk({nm, "_man_l"}, o_ml, '0);
    chk({nm, "_man_r"}, o_mr, '0);
  endtask

  int exp_t2l[4] = '{0, 1, 2, 3};
  int exp_t2r[4] = '{256, 257, 258, 259};
  int exp_t4l[4] = '{510, 511, 0, 1};
  int exp_t4r[4] = '{511, 0, 1, 2};
  int exp_t6l[2] = '{7, 8};
  int exp_t6r[2] = '{9, 10};
  bit seen_a[BRAM_DEPTH];
  int uniq, lasts;
  bit ok6;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_l     = '0;
    cmd_r     = '0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_at_release", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1);

    // Straight run, consumer always ready
    rmode = 1;
    clear_logs();
    send(0, 256, 4);
    wait_done(50);
    chk("t2_nrd", la_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_laddr", at(la_log, i), exp_t2l[i]);
      chk("t2_raddr", at(ra_log, i), exp_t2r[i]);
      chk("t2_idx", at(idx_log, i), i);
      chk("t2_last", at(last_log, i), (i == 3) ? 1 : 0);
    end
    chk("t2_first_rd", at(rd_cyc, 0) - at(acc_cyc, 0), 1);
    chk("t2_rd_span", at(rd_cyc, 3) - at(rd_cyc, 0), 3);
    chk("t2_latency", at(pop_cyc, 0) - at(rd_cyc, 0), 2);
    chk("t2_beat_span", at(pop_cyc, 3) - at(pop_cyc, 0), 3);
    chk("t2_done_at", at(done_cyc, 0) - at(pop_cyc, 3), 1);

    // Reset in the middle of a stalled command
    rmode = 0;
    clear_logs();
    send(20, 30, 8);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_release", cmd_ready, 0);
    @(negedge clk);
    chk("midrst_ready_after", {cmd_ready, busy}, 2'b10);

    // Backpressure: credit stops issue at two reads
    rmode = 0;
    clear_logs();
    send(100, 300, 8);
    repeat (8) @(negedge clk);
    chk("t3_reads_held", la_log.size(), 2);
    chk("t3_rd_en_low", ml_en, 0);
    chk("t3_head", {out_valid, o_idx}, {1'b1, 9'd0});
    rmode = 2;
    wait_done(200);
    chk("t3_nbeats", idx_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_idx", at(idx_log, i), i);
      chk("t3_laddr", at(la_log, i), 100 + i);
    end

    // Address wrap at the end of the BRAM
    rmode = 1;
    clear_logs();
    send(510, 511, 4);
    wait_done(50);
    chk("t4_nrd", la_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_laddr", at(la_log, i), exp_t4l[i]);
      chk("t4_raddr", at(ra_log, i), exp_t4r[i]);
      chk("t4_idx", at(idx_log, i), i);
    end

    // Zero-length command
    clear_logs();
    send(5, 6, 0);
    wait_done(5);
    chk("t5_zero_done", at(done_cyc, 0) - at(acc_cyc, 0), 1);
    chk("t5_zero_nrd", la_log.size(), 0);
    chk("t5_zero_nbeat", idx_log.size(), 0);

    // Full-depth command
    clear_logs();
    send(100, 200, 512);
    wait_done(700);
    chk("t5_full_nbeat", idx_log.size(), 512);
    chk("t5_full_lastidx", at(idx_log, 511), 511);
    foreach (seen_a[i]) seen_a[i] = 0;
    uniq  = 0;
    lasts = 0;
    foreach (la_log[i]) begin
      if (!seen_a[la_log[i]]) uniq++;
      seen_a[la_log[i]] = 1;
    end
    foreach (last_log[i]) lasts += last_log[i];
    chk("t5_full_unique", uniq, 512);
    chk("t5_full_lasts", lasts, 1);
    chk("t5_full_lastflag", at(last_log, 511), 1);
    chk("t5_wrap_l", at(la_log, 412), 0);
    chk("t5_end_l", at(la_log, 511), 99);
    chk("t5_wrap_r", at(ra_log, 312), 0);

    // Command held while busy
    rmode = 1;
    clear_logs();
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_l     = '0;
    cmd_r     = '0;
    cmd_len   = LEN_WIDTH'(3);
    ok6 = 0;
    for (int i = 0; i < 20 && !ok6; i++) begin
      @(negedge clk);
      if (cmd_ready) ok6 = 1;
    end
    chk("t6_first_accept", ok6, 1);
    @(posedge clk); #1;
    cmd_l   = ADDR_WIDTH'(7);
    cmd_r   = ADDR_WIDTH'(9);
    cmd_len = LEN_WIDTH'(2);
    @(negedge clk);
    chk("t6_busy_blocks", {busy, cmd_ready}, 2'b10);
    ok6 = 0;
    for (int i = 0; i < 50 && !ok6; i++) begin
      if (cmd_ready) ok6 = 1;
      else @(negedge clk);
    end
    chk("t6_second_accept", ok6, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done(50);
    chk("t6_naccept", acc_cyc.size(), 2);
    chk("t6_accept_after_done",
        at(acc_cyc, 1) - at(done_cyc, 0), 1);
    chk("t6_first_rd", at(rd_cyc, 3) - at(acc_cyc, 1), 1);
    for (int i = 0; i < 2; i++) begin
      chk("t6_laddr", at(la_log, 3 + i), exp_t6l[i]);
      chk("t6_raddr", at(ra_log, 3 + i), exp_t6r[i]);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
